// File: rtl/tdp36k_port_arbiter_pkg.sv
// Shared types and constants for the TDP36K port arbiter.
// Holds the controller state encoding, default geometry and a small id helper.
package tdp36k_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W = 32'd10;
    localparam int unsigned DEF_DATA_W = 32'd36;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } arb_state_e;

    // Expand a requester id (0/1) into its one-hot valid vector.
    function automatic logic [1:0] id_to_onehot(input logic id);
        logic [1:0] oh;
        if (id) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/tdp36k_port_arbiter_if.sv
// Bundle of requester handshakes, clear control and RAM port pins for one
// arbitrated TDP36K port. The arbiter takes the slave side.
interface tdp36k_port_arbiter_if
    import tdp36k_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              clr_start;
    logic              clr_busy;
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic              mem_ren;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  clr_start, r0_req, r0_we, r0_addr, r0_wdata,
               r1_req, r1_we, r1_addr, r1_wdata, mem_rdata,
        output clr_busy, r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, rdata,
               mem_addr, mem_wen, mem_ren, mem_wdata
    );

    modport master (
        output clr_start, r0_req, r0_we, r0_addr, r0_wdata,
               r1_req, r1_we, r1_addr, r1_wdata, mem_rdata,
        input  clr_busy, r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, rdata,
               mem_addr, mem_wen, mem_ren, mem_wdata
    );

endinterface

// File: rtl/tdp36k_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. On a tie the requester that did not win last
// time is granted; the pointer moves on every grant. Reset points at r1 so
// r0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);
    logic       last_q;
    logic       last_d;
    logic [1:0] gnt_s;

    // Pick the winner for this cycle from requests and the last-grant pointer.
    always_comb begin
        gnt_s = 2'b00;
        if (adv) begin
            case (req)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11:   gnt_s = last_q ? 2'b01 : 2'b10;
                default: gnt_s = 2'b00;
            endcase
        end else begin
            gnt_s = 2'b00;
        end
    end

    // Move the pointer to whoever was just granted; hold it otherwise.
    always_comb begin
        last_d = last_q;
        if (gnt_s != 2'b00) begin
            last_d = gnt_s[1];
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/tdp36k_port_arbiter.sv
// Shares one TDP36K RAM port between two requesters with round-robin
// arbitration, a registered read-data path tagged per requester, and a
// clear sequencer that sweeps CLR_VAL over every word.
module tdp36k_port_arbiter
    import tdp36k_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W  = DEF_ADDR_W,
    parameter int unsigned       DATA_W  = DEF_DATA_W,
    parameter logic [DATA_W-1:0] CLR_VAL = {DATA_W{1'b0}}
) (
    input  logic                  clock0,
    input  logic                  reset,
    tdp36k_port_arbiter_if.slave  bus
);
    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [ADDR_W-1:0] clr_cnt_d;
    logic              s1_vld_q;
    logic              s1_vld_d;
    logic              s1_id_q;
    logic              s1_id_d;
    logic [1:0]        rvalid_q;
    logic [1:0]        rvalid_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    logic              arb_adv_s;
    logic [1:0]        arb_gnt_s;
    logic              granted_s;
    logic              win_id_s;
    logic              win_we_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;
    logic              rd_issue_s;
    logic              inflight_s;
    logic              pipe_empty_s;
    logic              last_clr_s;

    // Grants are only issued in ARB and never while reset is asserted.
    assign arb_adv_s = (state_q == ST_ARB) && !reset;

    rr_arb2 u_rr_arb2 (
        .clk (clock0),
        .rst (reset),
        .req ({bus.r1_req, bus.r0_req}),
        .adv (arb_adv_s),
        .gnt (arb_gnt_s)
    );

    assign granted_s    = arb_gnt_s != 2'b00;
    assign win_id_s     = arb_gnt_s[1];
    assign win_we_s     = win_id_s ? bus.r1_we    : bus.r0_we;
    assign win_addr_s   = win_id_s ? bus.r1_addr  : bus.r0_addr;
    assign win_wdata_s  = win_id_s ? bus.r1_wdata : bus.r0_wdata;
    assign rd_issue_s   = granted_s && !win_we_s;
    // Tag pipe covers the capture stage and the rvalid stage.
    assign pipe_empty_s = !s1_vld_q && (rvalid_q == 2'b00);
    // A read issued in the clr_start cycle itself still counts as in flight.
    assign inflight_s   = !pipe_empty_s || rd_issue_s;
    assign last_clr_s   = clr_cnt_q == {ADDR_W{1'b1}};

    // Controller next state and clear counter.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_ARB: begin
                if (bus.clr_start) begin
                    state_d   = inflight_s ? ST_DRAIN : ST_CLEAR;
                    clr_cnt_d = {ADDR_W{1'b0}};
                end else begin
                    state_d   = ST_ARB;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty_s) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_CLEAR: begin
                if (last_clr_s) begin
                    state_d   = ST_ARB;
                    clr_cnt_d = {ADDR_W{1'b0}};
                end else begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = clr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d   = ST_ARB;
                clr_cnt_d = {ADDR_W{1'b0}};
            end
        endcase
    end

    // RAM port drive: clear sweep, granted access, or idle.
    always_comb begin
        bus.mem_addr  = {ADDR_W{1'b0}};
        bus.mem_wdata = {DATA_W{1'b0}};
        bus.mem_wen   = 1'b0;
        bus.mem_ren   = 1'b0;
        if (state_q == ST_CLEAR) begin
            bus.mem_addr  = clr_cnt_q;
            bus.mem_wdata = CLR_VAL;
            bus.mem_wen   = 1'b1;
        end else if (granted_s) begin
            bus.mem_addr  = win_addr_s;
            bus.mem_wdata = win_wdata_s;
            bus.mem_wen   = win_we_s;
            bus.mem_ren   = !win_we_s;
        end else begin
            bus.mem_wen   = 1'b0;
            bus.mem_ren   = 1'b0;
        end
    end

    // Read tag pipe and output data register next values.
    always_comb begin
        s1_vld_d = rd_issue_s;
        s1_id_d  = win_id_s;
        rvalid_d = 2'b00;
        rdata_d  = rdata_q;
        if (s1_vld_q) begin
            rvalid_d = id_to_onehot(s1_id_q);
            rdata_d  = bus.mem_rdata;
        end else begin
            rvalid_d = 2'b00;
            rdata_d  = rdata_q;
        end
    end

    // State, counter, tag pipe and read data registers.
    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_ARB;
            clr_cnt_q <= {ADDR_W{1'b0}};
            s1_vld_q  <= 1'b0;
            s1_id_q   <= 1'b0;
            rvalid_q  <= 2'b00;
            rdata_q   <= {DATA_W{1'b0}};
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            s1_vld_q  <= s1_vld_d;
            s1_id_q   <= s1_id_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.clr_busy  = state_q == ST_CLEAR;
    assign bus.r0_gnt    = arb_gnt_s[0];
    assign bus.r1_gnt    = arb_gnt_s[1];
    assign bus.r0_rvalid = rvalid_q[0];
    assign bus.r1_rvalid = rvalid_q[1];
    assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_tdp36k_port_arbiter.sv
// Self-checking bench for tdp36k_port_arbiter: random and directed traffic
// against a reference model built from queues and an array image of memory.
module tb_tdp36k_port_arbiter;
    import tdp36k_ctrl_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 36;
    localparam int DEPTH = 1024;

    logic clock0 = 1'b0;
    logic reset  = 1'b1;
    always #5 clock0 = ~clock0;

    tdp36k_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    tdp36k_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLR_VAL(36'h0)) dut (
        .clock0 (clock0),
        .reset  (reset),
        .bus    (bus.slave)
    );

    // RAM port model: synchronous write, read data one cycle after ren.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clock0) begin
        if (bus.mem_wen) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_ren) bus.mem_rdata <= ram[bus.mem_addr];
    end

    // Stimulus state
    logic          dreq [2];
    logic          dwe  [2];
    logic [AW-1:0] daddr[2];
    logic [DW-1:0] dwd  [2];
    logic          dclr;

    // Reference model
    typedef struct { int due; int id; logic [DW-1:0] d; } rd_t;
    rd_t           m_q[$];
    logic [DW-1:0] m_mem [DEPTH];
    int            m_last;
    int            m_mode;     // 0 arbitrate, 1 drain, 2 clear
    int            m_clr_cnt;
    logic [DW-1:0] m_rdata;
    int            cyc;

    logic [88:0]   exp_v, obs_v;
    logic [1:0]    obs_gnt, obs_rv, exp_gnt;
    logic          obs_busy;
    logic [DW-1:0] obs_rdata;

    int checks = 0;
    int errors = 0;

    task automatic apply();
        bus.r0_req = dreq[0]; bus.r0_we = dwe[0]; bus.r0_addr = daddr[0]; bus.r0_wdata = dwd[0];
        bus.r1_req = dreq[1]; bus.r1_we = dwe[1]; bus.r1_addr = daddr[1]; bus.r1_wdata = dwd[1];
        bus.clr_start = dclr;
    endtask

    task automatic model_reset();
        m_mode = 0; m_last = 1; m_clr_cnt = 0; m_rdata = '0;
        m_q.delete();
    endtask

    // One clock: drive inputs, sample at negedge, advance the model.
    task automatic tick();
        int win;
        logic inflight, pipe_empty, ewen, eren;
        logic [1:0] eg, erv;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ewd;
        apply();
        @(negedge clock0);
        cyc++;
        win = -1;
        if (m_mode == 0) begin
            if (dreq[0] && dreq[1]) win = (m_last == 1) ? 0 : 1;
            else if (dreq[0]) win = 0;
            else if (dreq[1]) win = 1;
        end
        eg = 2'b00; erv = 2'b00; ewen = 1'b0; eren = 1'b0; eaddr = '0; ewd = '0;
        if (win >= 0) begin
            eg[win] = 1'b1; ewen = dwe[win]; eren = !dwe[win]; eaddr = daddr[win]; ewd = dwd[win];
        end
        if (m_mode == 2) begin
            ewen = 1'b1; eaddr = AW'(m_clr_cnt); ewd = 36'h0;
        end
        pipe_empty = (m_q.size() == 0);
        inflight   = !pipe_empty || (win >= 0 && !dwe[win]);
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            erv[m_q[0].id] = 1'b1;
            m_rdata = m_q[0].d;
            void'(m_q.pop_front());
        end
        exp_gnt = eg;
        exp_v = {eg, erv, (m_mode == 2), m_rdata, ewen, eren, eaddr, ewd};
        obs_gnt   = {bus.r1_gnt, bus.r0_gnt};
        obs_rv    = {bus.r1_rvalid, bus.r0_rvalid};
        obs_busy  = bus.clr_busy;
        obs_rdata = bus.rdata;
        obs_v = {obs_gnt, obs_rv, obs_busy, obs_rdata, bus.mem_wen, bus.mem_ren, bus.mem_addr, bus.mem_wdata};
        if (win >= 0) begin
            m_last = win;
            if (dwe[win]) m_mem[daddr[win]] = dwd[win];
            else m_q.push_back('{cyc + 2, win, m_mem[daddr[win]]});
        end
        case (m_mode)
            0: if (dclr) begin m_mode = inflight ? 1 : 2; m_clr_cnt = 0; end
            1: if (pipe_empty) m_mode = 2;
            2: begin
                m_mem[m_clr_cnt] = 36'h0;
                m_clr_cnt++;
                if (m_clr_cnt == DEPTH) begin m_mode = 0; m_clr_cnt = 0; end
            end
            default: m_mode = 0;
        endcase
        @(posedge clock0);
        #1;
    endtask

    // Drop requests that the model says were just granted.
    task automatic retire();
        for (int i = 0; i < 2; i++) if (exp_gnt[i]) dreq[i] = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clock0);
        @(posedge clock0);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [88:0] outs;
        dreq[0] = 1'b1; dreq[1] = 1'b1; dwe[0] = 1'b1; daddr[0] = 10'd9; dwd[0] = 36'h1_2345_6789;
        apply();
        #2;
        outs = {bus.r1_gnt, bus.r0_gnt, bus.r1_rvalid, bus.r0_rvalid, bus.clr_busy, bus.rdata,
                bus.mem_wen, bus.mem_ren, bus.mem_addr, bus.mem_wdata};
        checks++;
        if (outs !== 89'h0) begin
            errors++; $display("FAIL reset_outputs got=%h want=0", outs);
        end
        release_reset();
        dreq[0] = 1'b0; dreq[1] = 1'b0;
    endtask

    task automatic test_write_read();
        dreq[0] = 1'b1; dwe[0] = 1'b1; daddr[0] = 10'd5; dwd[0] = 36'hA_5555_AAAA;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin dreq[1] = 1'b1; dwe[1] = 1'b0; daddr[1] = 10'd5; end
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL write_read cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
            end
            if (k == 1) begin
                checks++;
                if (obs_gnt !== 2'b10) begin errors++; $display("FAIL r1_gnt got=%b want=10", obs_gnt); end
            end
            if (k == 3) begin
                checks++;
                if ({obs_rv, obs_rdata} !== {2'b10, 36'hA_5555_AAAA}) begin
                    errors++; $display("FAIL r1_read_data got=%b/%h want=10/a5555aaaa", obs_rv, obs_rdata);
                end
            end
            retire();
        end
    endtask

    task automatic test_clear_basic();
        int busy_n, pulses;
        logic [AW-1:0] a3[3];
        a3[0] = 10'd0; a3[1] = 10'd1023; a3[2] = 10'd512;
        for (int k = 0; k < 3; k++) begin
            dreq[0] = 1'b1; dwe[0] = 1'b1; daddr[0] = a3[k]; dwd[0] = 36'hF_FFFF_FFFF;
            tick(); retire();
        end
        dclr = 1'b1; tick(); dclr = 1'b0;
        busy_n = (obs_busy === 1'b1) ? 1 : 0;
        for (int k = 0; k < 1100; k++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL clear_sweep cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
            end
            if (obs_busy) busy_n++;
            else if (busy_n > 0) break;
        end
        checks++;
        if (busy_n !== 1024) begin errors++; $display("FAIL clear_length got=%0d want=1024", busy_n); end
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (k < 3) begin dreq[1] = 1'b1; dwe[1] = 1'b0; daddr[1] = a3[k]; end
            tick(); retire();
            if (obs_rv[1]) begin
                pulses++;
                checks++;
                if (obs_rdata !== 36'h0) begin errors++; $display("FAIL cleared_read got=%h want=0", obs_rdata); end
            end
        end
        checks++;
        if (pulses !== 3) begin errors++; $display("FAIL cleared_read_count got=%0d want=3", pulses); end
    endtask

    task automatic test_alternate();
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!dreq[i] && k < 6) begin
                    dreq[i] = 1'b1; dwe[i] = 1'b0; daddr[i] = AW'($urandom_range(0, 1023));
                end
            end
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL alternate cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
            end
            if (k >= 2 && k < 8) begin
                checks++;
                if (obs_rv === 2'b00) begin errors++; $display("FAIL rvalid_bubble cyc=%0d got=00 want=nonzero", cyc); end
            end
            retire();
        end
    endtask

    task automatic test_random();
        logic [63:0] r64;
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!dreq[i] && ($urandom_range(0, 2) != 0)) begin
                    r64 = {$urandom, $urandom};
                    dreq[i] = 1'b1; dwe[i] = r64[40]; daddr[i] = AW'($urandom_range(0, 15)); dwd[i] = r64[35:0];
                end
            end
            dclr = (k == 200);
            tick();
            dclr = 1'b0;
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
            end
            retire();
        end
        while ((dreq[0] || dreq[1] || m_q.size() > 0 || m_mode != 0) && cyc < 60000) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL random_tail cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
            end
            retire();
        end
    endtask

    task automatic test_drain();
        int last_rv, first_busy, gnt_busy;
        logic done;
        last_rv = 0; first_busy = 0; gnt_busy = 0; done = 1'b0;
        dreq[0] = 1'b1; dwe[0] = 1'b0; daddr[0] = 10'd3;
        dreq[1] = 1'b1; dwe[1] = 1'b0; daddr[1] = 10'd4;
        for (int k = 0; k < 1200 && !done; k++) begin
            if (k == 2) begin dreq[0] = 1'b1; dwe[0] = 1'b1; daddr[0] = 10'd7; dwd[0] = 36'h3_0000_0007; dclr = 1'b1; end
            if (k == 3) begin dreq[0] = 1'b1; dwe[0] = 1'b1; daddr[0] = 10'd8; dwd[0] = 36'h3_0000_0008; end
            tick();
            dclr = 1'b0;
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL drain cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
            end
            if (obs_rv != 2'b00) last_rv = cyc;
            if (obs_busy && first_busy == 0) first_busy = cyc;
            if (obs_busy && obs_gnt != 2'b00) gnt_busy++;
            if (k > 3 && obs_gnt != 2'b00 && !obs_busy && first_busy != 0) done = 1'b1;
            retire();
        end
        checks++;
        if (gnt_busy !== 0) begin errors++; $display("FAIL gnt_during_clear got=%0d want=0", gnt_busy); end
        checks++;
        if (!(first_busy > last_rv && last_rv > 0)) begin
            errors++; $display("FAIL drain_order got busy@%0d rvalid@%0d want busy after rvalid", first_busy, last_rv);
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL stalled_write got=not_granted want=granted"); end
    endtask

    task automatic test_restart();
        int n;
        dclr = 1'b1; tick(); dclr = 1'b0;
        n = (obs_busy === 1'b1) ? 1 : 0;
        for (int k = 0; k < 1100; k++) begin
            dclr = (n == 300);
            tick();
            dclr = 1'b0;
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL restart cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
            end
            if (obs_busy) n++;
            else if (n > 0) break;
        end
        checks++;
        if (n !== 1024) begin errors++; $display("FAIL restart_length got=%0d want=1024", n); end
    endtask

    task automatic test_reset_mid_clear();
        logic [DW-1:0] v100, v1023;
        logic [88:0] outs;
        logic [63:0] r64;
        r64 = {$urandom, $urandom}; v100 = r64[35:0] | 36'h1;
        r64 = {$urandom, $urandom}; v1023 = r64[35:0] | 36'h2;
        dreq[0] = 1'b1; dwe[0] = 1'b1; daddr[0] = 10'd100; dwd[0] = v100; tick(); retire();
        dreq[0] = 1'b1; dwe[0] = 1'b1; daddr[0] = 10'd1023; dwd[0] = v1023; tick(); retire();
        dreq[0] = 1'b1; dwe[0] = 1'b1; daddr[0] = 10'd99; dwd[0] = 36'h5_5555_5555; tick(); retire();
        dclr = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            dclr = 1'b0;
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL mid_clear cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
            end
        end
        reset = 1'b1;
        #2;
        outs = {bus.r1_gnt, bus.r0_gnt, bus.r1_rvalid, bus.r0_rvalid, bus.clr_busy, bus.rdata,
                bus.mem_wen, bus.mem_ren, bus.mem_addr, bus.mem_wdata};
        checks++;
        if (outs !== 89'h0) begin errors++; $display("FAIL reset_mid_clear_outputs got=%h want=0", outs); end
        release_reset();
        dreq[0] = 1'b1; dwe[0] = 1'b0; daddr[0] = 10'd99;
        dreq[1] = 1'b1; dwe[1] = 1'b0; daddr[1] = 10'd100;
        for (int k = 0; k < 7; k++) begin
            if (k == 2) begin dreq[0] = 1'b1; dwe[0] = 1'b0; daddr[0] = 10'd1023; end
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL after_reset cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
            end
            if (k == 0) begin
                checks++;
                if (obs_gnt !== 2'b01) begin errors++; $display("FAIL first_tie got=%b want=01", obs_gnt); end
            end
            if (obs_rv[1]) begin
                checks++;
                if (obs_rdata !== v100) begin errors++; $display("FAIL retained_100 got=%h want=%h", obs_rdata, v100); end
            end
            retire();
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 36'h0;
        for (int i = 0; i < 2; i++) begin dreq[i] = 1'b0; dwe[i] = 1'b0; daddr[i] = '0; dwd[i] = '0; end
        dclr = 1'b0;
        cyc = 0;
        model_reset();
        apply();
        @(posedge clock0);
        #1;
        test_reset();
        test_write_read();
        test_clear_basic();
        test_alternate();
        test_random();
        test_drain();
        test_restart();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
